// File: rtl/imm_ext_arbiter.sv
// Two-port round-robin immediate extender feeding a 2-entry response FIFO.
// Build option: define IMM_EXT_ZEXT_EN to honour the reqN_zext inputs (otherwise always sign-extend).
module imm_ext_arbiter #(
  parameter int SIZE_IN  = 16,
  parameter int SIZE_OUT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic [SIZE_IN-1:0]  req0_imm,
  input  logic                req0_zext,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [SIZE_IN-1:0]  req1_imm,
  input  logic                req1_zext,
  output logic                req1_ready,
  output logic                rsp_valid,
  output logic [SIZE_OUT-1:0] rsp_data,
  output logic                rsp_id,
  input  logic                rsp_ready,
  output logic                busy
);

  localparam int EXT_W = SIZE_OUT - SIZE_IN;

  logic [1:0]          count_r;
  logic                rd_ptr_r;
  logic                wr_ptr_r;
  logic                prio_r;
  logic [SIZE_OUT-1:0] mem_data_r [2];
  logic                mem_id_r [2];
  logic                rsp_valid_r;
  logic [SIZE_OUT-1:0] rsp_data_r;
  logic                rsp_id_r;
  logic                busy_r;

  logic                space_s;
  logic                gnt_valid_s;
  logic                gnt_id_s;
  logic                push_s;
  logic                pop_s;
  logic [1:0]          count_nxt_s;
  logic                rd_nxt_s;
  logic [SIZE_IN-1:0]  imm_sel_s;
  logic                zext_sel_s;
  logic [SIZE_OUT-1:0] ext_s;
  logic [SIZE_OUT-1:0] head_data_s;
  logic                head_id_s;

`ifdef IMM_EXT_ZEXT_EN
  function automatic logic [SIZE_OUT-1:0] extend(input logic [SIZE_IN-1:0] imm, input logic zext);
    return {{EXT_W{imm[SIZE_IN-1] & ~zext}}, imm};
  endfunction
`else
  function automatic logic [SIZE_OUT-1:0] extend(input logic [SIZE_IN-1:0] imm);
    return {{EXT_W{imm[SIZE_IN-1]}}, imm};
  endfunction
`endif

  // Grant selection, handshake qualification and next-head computation.
  always_comb begin
    space_s     = (count_r < 2'd2) || rsp_ready;
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01: begin gnt_valid_s = 1'b1; gnt_id_s = 1'b0;   end
      2'b10: begin gnt_valid_s = 1'b1; gnt_id_s = 1'b1;   end
      2'b11: begin gnt_valid_s = 1'b1; gnt_id_s = prio_r; end
      default: begin gnt_valid_s = 1'b0; gnt_id_s = 1'b0; end
    endcase
    // Readies are forced low while reset is asserted, even with an empty FIFO.
    push_s     = space_s & gnt_valid_s & rst_n;
    req0_ready = push_s & ~gnt_id_s;
    req1_ready = push_s & gnt_id_s;
    pop_s      = rsp_valid_r & rsp_ready;

    imm_sel_s  = gnt_id_s ? req1_imm : req0_imm;
    zext_sel_s = gnt_id_s ? req1_zext : req0_zext;
`ifdef IMM_EXT_ZEXT_EN
    ext_s = extend(imm_sel_s, zext_sel_s);
`else
    ext_s = extend(imm_sel_s);
`endif

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
    rd_nxt_s = rd_ptr_r ^ pop_s;

    // The new head is the entry being written when it lands on the next read slot.
    if (push_s && (wr_ptr_r == rd_nxt_s)) begin
      head_data_s = ext_s;
      head_id_s   = gnt_id_s;
    end else begin
      head_data_s = mem_data_r[rd_nxt_s];
      head_id_s   = mem_id_r[rd_nxt_s];
    end
  end

`ifndef IMM_EXT_ZEXT_EN
  logic unused_zext_s;
  assign unused_zext_s = zext_sel_s;
`endif

  // FIFO storage, pointers, arbitration priority and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r       <= 2'd0;
      rd_ptr_r      <= 1'b0;
      wr_ptr_r      <= 1'b0;
      prio_r        <= 1'b0;
      mem_data_r[0] <= '0;
      mem_data_r[1] <= '0;
      mem_id_r[0]   <= 1'b0;
      mem_id_r[1]   <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= '0;
      rsp_id_r      <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      if (push_s) begin
        mem_data_r[wr_ptr_r] <= ext_s;
        mem_id_r[wr_ptr_r]   <= gnt_id_s;
        wr_ptr_r             <= ~wr_ptr_r;
        prio_r               <= ~gnt_id_s;
      end
      rd_ptr_r    <= rd_nxt_s;
      count_r     <= count_nxt_s;
      rsp_valid_r <= (count_nxt_s != 2'd0);
      busy_r      <= (count_nxt_s != 2'd0);
      // Output data holds its last value once the FIFO empties.
      if (count_nxt_s != 2'd0) begin
        rsp_data_r <= head_data_s;
        rsp_id_r   <= head_id_s;
      end
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;
  assign busy      = busy_r;

endmodule
